// File: rtl/fifo_stream_reader.sv
// Drains a programmed number of words from the sync FIFO and emits them as one AXI-Stream frame.
// Optional stall statistics output enabled by defining READER_STATS_EN.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_W-1:0]      cfg_len,
  output logic                  busy,
  output logic                  done,
  input  logic                  fifo_ovalid,
  output logic                  fifo_oready,
  input  logic [DATA_WIDTH-1:0] fifo_odata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast
`ifdef READER_STATS_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  // Handshakes: a FIFO word moves when fifo_ovalid & fifo_oready, a stream beat
  // moves when m_tvalid & m_tready; neither valid waits on its own ready.
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      popped_q, popped_d;
  logic [LEN_W-1:0]      sent_q, sent_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic [1:0]            buf_cnt_q, buf_cnt_d;

  logic pop;
  logic fire;
  logic last_beat;

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign fifo_oready = (state_q == RUN) && (popped_q != len_q) && (buf_cnt_q != 2'd2);
  assign m_tvalid    = (buf_cnt_q != 2'd0);
  assign m_tdata     = buf0_q;
  assign last_beat   = (sent_q == len_q - LEN_W'(1));
  assign m_tlast     = m_tvalid & last_beat;
  assign pop         = fifo_ovalid & fifo_oready;
  assign fire        = m_tvalid & m_tready;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    popped_d  = popped_q;
    sent_d    = sent_q;
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    buf_cnt_d = buf_cnt_q;

    // buf0 is always the head; buf1 only holds a word while buf0 is occupied
    case ({pop, fire})
      2'b10: begin
        if (buf_cnt_q == 2'd0) buf0_d = fifo_odata;
        else                   buf1_d = fifo_odata;
        buf_cnt_d = buf_cnt_q + 2'd1;
      end
      2'b01: begin
        buf0_d    = buf1_q;
        buf_cnt_d = buf_cnt_q - 2'd1;
      end
      2'b11: begin
        if (buf_cnt_q == 2'd1) begin
          buf0_d = fifo_odata;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fifo_odata;
        end
      end
      default: ;
    endcase

    if (pop)  popped_d = popped_q + LEN_W'(1);
    if (fire) sent_d   = sent_q + LEN_W'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d     = cfg_len;
          popped_d  = '0;
          sent_d    = '0;
          buf_cnt_d = 2'd0;
          state_d   = (cfg_len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (fire && last_beat) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      popped_q  <= '0;
      sent_q    <= '0;
      buf0_q    <= '0;
      buf1_q    <= '0;
      buf_cnt_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      popped_q  <= popped_d;
      sent_q    <= sent_d;
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
      buf_cnt_q <= buf_cnt_d;
    end
  end

`ifdef READER_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == IDLE && start) begin
      stall_cnt_d = '0;
    end else if (state_q == RUN && m_tvalid && !m_tready && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: FIFO model on the drain side, scoreboard on the stream side.
// Define READER_STATS_EN to also check the stall counter.
module tb_fifo_stream_reader;
  localparam int DW = 8;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic          busy;
  logic          done;
  logic          fifo_ovalid = 1'b0;
  logic          fifo_oready;
  logic [DW-1:0] fifo_odata = '0;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
`ifdef READER_STATS_EN
  logic [31:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(DW), .LEN_W(LW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cfg_len     (cfg_len),
    .busy        (busy),
    .done        (done),
    .fifo_ovalid (fifo_ovalid),
    .fifo_oready (fifo_oready),
    .fifo_odata  (fifo_odata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tdata     (m_tdata),
    .m_tlast     (m_tlast)
`ifdef READER_STATS_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  int            n_asserts = 0;
  int            n_fail = 0;
  logic [DW-1:0] fifo_m[$];
  logic [DW-1:0] exp_q[$];
  int            tb_buf = 0;
  int            beats = 0;
  int            pops = 0;
  int            cur_len = 0;
  int            cyc = 0;
  int            first_fire = 0;
  int            last_fire = 0;
  int            start_cyc = 0;
  int            hold_left = 0;
  bit            done_next = 1'b0;
  bit            stall_pending = 1'b0;
  logic [DW-1:0] held = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_asserts++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic refresh_fifo();
    fifo_ovalid = (fifo_m.size() != 0);
    fifo_odata  = (fifo_m.size() != 0) ? fifo_m[0] : '0;
  endtask

  task automatic push_words(input int base, input int n);
    for (int i = 0; i < n; i++) fifo_m.push_back(DW'(base + i));
    refresh_fifo();
  endtask

  // Evaluate this cycle's handshakes, then advance one clock and settle.
  task automatic tick();
    bit pop;
    bit fire;
    logic [DW-1:0] e;
    pop  = fifo_ovalid & fifo_oready;
    fire = m_tvalid & m_tready;
    done_next = 1'b0;
    chk("m_tvalid", 32'(m_tvalid), 32'(tb_buf != 0));
    if (tb_buf == 2) chk("oready_when_full", 32'(fifo_oready), 32'd0);
    if (stall_pending) begin
      chk("hold_valid", 32'(m_tvalid), 32'd1);
      chk("hold_data", 32'(m_tdata), 32'(held));
    end
    stall_pending = m_tvalid & !m_tready;
    held = m_tdata;
    if (fire) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("m_tdata", 32'(m_tdata), 32'(e));
      end
      chk("m_tlast", 32'(m_tlast), 32'(beats == cur_len - 1));
      if (beats == 0) first_fire = cyc;
      last_fire = cyc;
      beats++;
      done_next = (beats == cur_len);
    end
    if (pop) begin
      exp_q.push_back(fifo_m.pop_front());
      pops++;
    end
    tb_buf = tb_buf + int'(pop) - int'(fire);
    @(posedge clk);
    #1;
    cyc++;
    refresh_fifo();
  endtask

  // mode 0: ready high; 1: ready toggles; 2: ready low for 5 valid cycles
  task automatic run_frame(input int len, input int mode, input bit mid_start);
    bit got_done;
    got_done = 1'b0;
    cur_len = len;
    beats = 0;
    pops = 0;
    hold_left = 5;
    m_tready = 1'b1;
    start = 1'b1;
    cfg_len = LW'(len);
    start_cyc = cyc;
    tick();
    start = 1'b0;
    chk("busy_run", 32'(busy), 32'd1);
`ifdef READER_STATS_EN
    chk("stall_cleared", stall_cnt, 32'd0);
`endif
    for (int i = 0; i < 200; i++) begin
      case (mode)
        1: m_tready = ~m_tready;
        2: begin
          if (m_tvalid && hold_left > 0) begin
            m_tready = 1'b0;
            hold_left--;
          end else begin
            m_tready = 1'b1;
          end
        end
        default: m_tready = 1'b1;
      endcase
      if (mid_start && i == 2) begin
        start = 1'b1;
        cfg_len = LW'(7);
      end else begin
        start = 1'b0;
      end
      tick();
      start = 1'b0;
      if (done_next) begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_done", 32'(busy), 32'd1);
        got_done = 1'b1;
        break;
      end
      chk("done_low", 32'(done), 32'd0);
    end
    chk("frame_done", 32'(got_done), 32'd1);
    m_tready = 1'b1;
    tick();
    chk("done_once", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("pop_count", 32'(pops), 32'(len));
    chk("beat_count", 32'(beats), 32'(len));
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_oready", 32'(fifo_oready), 32'd0);
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tlast", 32'(m_tlast), 32'd0);
    chk("rst_tdata", 32'(m_tdata), 32'd0);
`ifdef READER_STATS_EN
    chk("rst_stall", stall_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // full-rate frame and its latency
    push_words(8'h11, 4);
    run_frame(4, 0, 1'b0);
    chk("first_beat_latency", 32'(first_fire - start_cyc), 32'd2);
    chk("back_to_back", 32'(last_fire - first_fire), 32'd3);

    // backpressure every other cycle
    push_words(8'h20, 8);
    run_frame(8, 1, 1'b0);

    // length shorter than FIFO contents
    push_words(8'h31, 5);
    run_frame(3, 0, 1'b0);
    chk("leftover_words", 32'(fifo_m.size()), 32'd2);
    chk("leftover_valid", 32'(fifo_ovalid), 32'd1);
    run_frame(2, 0, 1'b0);

    // zero-length start, start during DONE, start while running
    chk("zl_busy_before", 32'(busy), 32'd0);
    start = 1'b1;
    cfg_len = '0;
    tick();
    chk("zl_done", 32'(done), 32'd1);
    chk("zl_busy", 32'(busy), 32'd1);
    cfg_len = LW'(5);
    tick();
    start = 1'b0;
    chk("zl_done_once", 32'(done), 32'd0);
    chk("start_in_done_ignored", 32'(busy), 32'd0);
    tick();
    chk("still_idle", 32'(busy), 32'd0);
    push_words(8'h41, 3);
    run_frame(3, 0, 1'b1);

    // reset mid-frame
    push_words(8'h51, 6);
    cur_len = 6;
    beats = 0;
    pops = 0;
    start = 1'b1;
    cfg_len = LW'(6);
    tick();
    start = 1'b0;
    for (int i = 0; i < 50 && beats < 2; i++) tick();
    chk("beats_before_reset", 32'(beats), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_oready", 32'(fifo_oready), 32'd0);
    chk("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("mid_rst_tlast", 32'(m_tlast), 32'd0);
    chk("mid_rst_tdata", 32'(m_tdata), 32'd0);
    exp_q.delete();
    fifo_m.delete();
    refresh_fifo();
    tb_buf = 0;
    stall_pending = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_words(8'h61, 2);
    run_frame(2, 0, 1'b0);

    // stalls held for five cycles after first valid
    push_words(8'h71, 4);
    run_frame(4, 2, 1'b0);
`ifdef READER_STATS_EN
    chk("stall_cnt_after_done", stall_cnt, 32'd5);
`endif
    push_words(8'h81, 1);
    run_frame(1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
